truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Self-checking stimulus controller for a 3-input, 1-output combinational circuit. On `start` it drives all eight input combinations onto `a`,`b`,`c` in ascending order and holds each for a programmable settle time. It samples the circuit output `d` for each combination, compares the captured 8-entry truth table against an expected table, and reports pass/fail with a mismatch mask. It sits between a host/test controller and any circuit under test with the shape `(a, b, c) -> d`.

## Interface
- `SETTLE`, default 2: extra cycles each vector is held before sampling. Each vector occupies SETTLE+1 cycles; legal range 0..15.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE
- `expected`  in  8  expected truth table, bit k = d for {a,b,c}=k; latched when start is accepted
- `d`  in  1  output of circuit under test
- `a`,`b`,`c`  out  1 each  stimulus; {a,b,c} = vector index, a = MSB
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse, results valid
- `pass`  out  1  mismatch == 0; valid from done until next accepted start
- `captured`  out  8  sampled truth table
- `mismatch`  out  8  captured ^ expected_latched
- `fail_count`  out  4  popcount(mismatch), 0..8

## Operation
- FSM states:
  - IDLE: stimulus 000, busy 0.
  - DRIVE: stimulus = idx, settle counter running.
  - DONE: single cycle, done = 1.
- IDLE/DONE + start → DRIVE:
  - idx = 0, settle counter = 0.
  - `expected` latched.
  - captured, mismatch, fail_count and pass cleared.
- DRIVE, counter < SETTLE: counter increments.
- DRIVE, counter == SETTLE:
  - captured[idx] <= d and counter cleared.
  - If idx == 7, go to DONE; otherwise idx increments.
- DONE → IDLE unconditionally.
  - mismatch, fail_count and pass update on entry to DONE and hold in IDLE.
- start while busy is ignored; no restart or queuing.
- Before any sweep, `pass` is 0.
- fail_count arithmetic is 4-bit and cannot overflow, since the maximum is 8.

## Timing
- Reset (async assert, sync-released behaviour on the next edge):
  - state IDLE; a, b, c, busy, done, pass = 0.
  - captured, mismatch, fail_count = 0; idx and counter = 0.
- start sampled high at edge E0 → busy = 1 and stimulus 000 from the cycle after E0.
- Vector k is driven during cycles k·(SETTLE+1)+1 … (k+1)·(SETTLE+1) after E0.
  - d is sampled at the rising edge closing the last of those cycles.
- done = 1 and busy = 0 in cycle 8·(SETTLE+1)+1 after E0.
  - SETTLE=2: cycle 25. SETTLE=0: cycle 9.
- start high during the DONE cycle is accepted: the next sweep begins the following cycle.
- rst_n low mid-sweep aborts immediately; no done pulse, results cleared.
- Stimulus changes only on clock edges. The settle window absorbs circuit-under-test combinational delay; sampling occurs SETTLE+1 cycles after a change.

## Structure
- Package `sweeper_pkg`:
  - state enum {IDLE, DRIVE, DONE}.
  - `NUM_VECTORS = 8`, `VEC_W = 3`.
- Sub-module `settle_timer`:
  - parameterised by SETTLE.
  - inputs clear/enable; output `expire` when count == SETTLE.
  - used by the FSM to advance idx.
- Popcount for fail_count is inline combinational logic in the top.

## Test plan
- Reset: assert rst_n=0 mid-idle → a/b/c/busy/done/pass = 0, captured = 8'h00, fail_count = 0.
- Circuit d=(a&b)|c, SETTLE=2, expected=8'hEA, start pulse → 24 busy cycles; done in cycle 25; captured=8'hEA, mismatch=8'h00, pass=1, fail_count=0.
- Same circuit, expected=8'hEB → mismatch=8'h01, pass=0, fail_count=1; stimulus visits 000..111 in order, each held 3 cycles.
- d tied 0, expected=8'hFF → mismatch=8'hFF, fail_count=8, pass=0.
- start re-pulsed during vector 3 → ignored, done still in cycle 25.
  - Then rst_n low during vector 5 → busy=0, stimulus 000, no done pulse.
  - A fresh start then completes normally with correct results.
- SETTLE=0 build, d=a^b^c, expected=8'h96 → done in cycle 9, pass=1.
  - start held high through DONE → second sweep begins immediately and passes again.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// sweeper_pkg: shared FSM state type and vector geometry for the truth table sweeper
package sweeper_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int NUM_VECTORS = 8;
  localparam int VEC_W = 3;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: host/circuit-under-test bundle of the sweeper
// master: host and circuit side (drives start, expected, d); slave: the sweeper itself
interface truth_table_sweeper_if;
  import sweeper_pkg::*;
  logic start;
  logic [NUM_VECTORS-1:0] expected;
  logic d;
  logic a, b, c;
  logic busy, done, pass;
  logic [NUM_VECTORS-1:0] captured, mismatch;
  logic [3:0] fail_count;
  modport master (output start, expected, d, input a, b, c, busy, done, pass, captured, mismatch, fail_count);
  modport slave (input start, expected, d, output a, b, c, busy, done, pass, captured, mismatch, fail_count);
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: counts 0..SETTLE while enabled; expire flags the sampling cycle
// ports: clk, rst_n, clear (restart at 0), enable (count), expire (count == SETTLE)
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [3:0] cnt;
  assign expire = cnt == 4'(SETTLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= expire ? '0 : cnt + 4'd1;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps {a,b,c} through 000..111, samples d, grades against expected
// ports: clk, rst_n (async, active-low), bus (slave side of truth_table_sweeper_if)
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst_n,
  truth_table_sweeper_if.slave bus
);
  state_t state, state_d;
  logic [VEC_W-1:0] idx;
  logic [NUM_VECTORS-1:0] exp_q, cap_d, mis_d;
  logic [3:0] pop;
  logic accept, expire, last;
  assign accept = bus.start && state != DRIVE;
  assign last = expire && idx == VEC_W'(NUM_VECTORS - 1);
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(accept),
    .enable(state == DRIVE),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = accept ? DRIVE : state == DRIVE ? (last ? DONE : DRIVE) : IDLE;
  end
  // grading must see the final sample, so it works on the table as it will be after this edge
  always_comb begin
    cap_d = bus.captured;
    cap_d[idx] = bus.d;
    mis_d = cap_d ^ exp_q;
    pop = '0;
    for (int i = 0; i < NUM_VECTORS; i++) pop = pop + 4'(mis_d[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      exp_q <= '0;
      bus.captured <= '0;
      bus.mismatch <= '0;
      bus.fail_count <= '0;
      bus.pass <= 1'b0;
    end else if (accept) begin
      idx <= '0;
      exp_q <= bus.expected;
      bus.captured <= '0;
      bus.mismatch <= '0;
      bus.fail_count <= '0;
      bus.pass <= 1'b0;
    end else if (state == DRIVE && expire) begin
      bus.captured <= cap_d;
      idx <= idx + 1'b1;
      if (last) begin
        bus.mismatch <= mis_d;
        bus.fail_count <= pop;
        bus.pass <= mis_d == '0;
      end
    end
  assign {bus.a, bus.b, bus.c} = state == DRIVE ? idx : '0;
  assign bus.busy = state == DRIVE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of the sweeper with SETTLE=2 and SETTLE=0 builds
module tb_truth_table_sweeper;
  logic clk, rst_n;
  int mode;
  int passed, total;
  truth_table_sweeper_if s2 ();
  truth_table_sweeper_if s0 ();
  truth_table_sweeper #(.SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(s2));
  truth_table_sweeper #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(s0));
  assign s2.d = mode == 0 ? ((s2.a & s2.b) | s2.c) : 1'b0;
  assign s0.d = s0.a ^ s0.b ^ s0.c;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic sweep2(input logic [7:0] exp, input logic [7:0] cap, input logic [7:0] mis,
                        input logic [3:0] fc, input logic ps, input int restart_at);
    @(negedge clk);
    s2.start = 1'b1;
    s2.expected = exp;
    @(negedge clk);
    s2.start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      s2.start = n == restart_at;
      s2.expected = n == restart_at ? ~exp : exp;
      chk("busy", s2.busy, 1);
      chk("done_early", s2.done, 0);
      chk("vec", {s2.a, s2.b, s2.c}, (n - 1) / 3);
      @(negedge clk);
    end
    s2.start = 1'b0;
    chk("done25", s2.done, 1);
    chk("busy25", s2.busy, 0);
    chk("captured", s2.captured, cap);
    chk("mismatch", s2.mismatch, mis);
    chk("fail_count", s2.fail_count, fc);
    chk("pass", s2.pass, ps);
    @(negedge clk);
    chk("done_pulse", s2.done, 0);
    chk("pass_hold", s2.pass, ps);
    chk("cap_hold", s2.captured, cap);
  endtask
  initial begin
    int done_seen;
    passed = 0;
    total = 0;
    mode = 0;
    rst_n = 1'b0;
    s2.start = 1'b0;
    s2.expected = '0;
    s0.start = 1'b0;
    s0.expected = '0;
    repeat (2) @(negedge clk);
    chk("rst_abc", {s2.a, s2.b, s2.c}, 0);
    chk("rst_busy", s2.busy, 0);
    chk("rst_done", s2.done, 0);
    chk("rst_pass", s2.pass, 0);
    chk("rst_cap", s2.captured, 0);
    chk("rst_fc", s2.fail_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_pass", s2.pass, 0);
    sweep2(8'hEA, 8'hEA, 8'h00, 4'd0, 1'b1, 0);
    rst_n = 1'b0;
    #1;
    chk("idle_rst_pass", s2.pass, 0);
    chk("idle_rst_cap", s2.captured, 0);
    chk("idle_rst_fc", s2.fail_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep2(8'hEB, 8'hEA, 8'h01, 4'd1, 1'b0, 0);
    mode = 1;
    sweep2(8'hFF, 8'h00, 8'hFF, 4'd8, 1'b0, 0);
    mode = 0;
    sweep2(8'hEA, 8'hEA, 8'h00, 4'd0, 1'b1, 10);
    @(negedge clk);
    s2.start = 1'b1;
    s2.expected = 8'hEA;
    @(negedge clk);
    s2.start = 1'b0;
    repeat (15) @(negedge clk);
    chk("vec5", {s2.a, s2.b, s2.c}, 5);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", s2.busy, 0);
    chk("abort_vec", {s2.a, s2.b, s2.c}, 0);
    chk("abort_done", s2.done, 0);
    chk("abort_cap", s2.captured, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 30; n++) begin
      done_seen |= int'(s2.done);
      @(negedge clk);
    end
    chk("abort_no_done", done_seen, 0);
    sweep2(8'hEA, 8'hEA, 8'h00, 4'd0, 1'b1, 0);
    s0.start = 1'b1;
    s0.expected = 8'h96;
    @(negedge clk);
    for (int n = 1; n <= 8; n++) begin
      chk("s0_busy", s0.busy, 1);
      chk("s0_vec", {s0.a, s0.b, s0.c}, n - 1);
      @(negedge clk);
    end
    chk("s0_done9", s0.done, 1);
    chk("s0_pass", s0.pass, 1);
    chk("s0_cap", s0.captured, 8'h96);
    @(negedge clk);
    s0.start = 1'b0;
    chk("s0_restart_busy", s0.busy, 1);
    chk("s0_restart_vec", {s0.a, s0.b, s0.c}, 0);
    chk("s0_restart_pass", s0.pass, 0);
    repeat (8) @(negedge clk);
    chk("s0_done2", s0.done, 1);
    chk("s0_pass2", s0.pass, 1);
    chk("s0_mis2", s0.mismatch, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
